// File: rtl/blk_alloc_pkg.sv
// Shared types and helpers for the block-allocation client.
// Holds the occupy FSM encoding, the default address width and the counter-width rule.
package blk_alloc_pkg;

   localparam int AWIDTH_DEF = 10;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } ocp_state_t;

   // Width needed to count 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/addr_fifo.sv
// Synchronous first-word-fall-through address FIFO; head valid the cycle after a push.
// A push while full is dropped unless a pop happens on the same edge; head reads 0 when empty.
module addr_fifo
   import blk_alloc_pkg::*;
#(
   parameter int WIDTH = AWIDTH_DEF,
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic [WIDTH-1:0]            push_dat,
   input  logic                        pop,
   output logic [WIDTH-1:0]            head_dat,
   output logic [cnt_width(DEPTH)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign head_dat = empty ? '0 : mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/blk_alloc_client.sv
// Occupy/release initiator: prefetches pre-occupied blocks for zero-latency grants and
// serialises reader releases onto rls_vld (2-cycle release latency, 1/cycle throughput).
module blk_alloc_client
   import blk_alloc_pkg::*;
#(
   parameter int AWIDTH    = AWIDTH_DEF,
   parameter int PF_DEPTH  = 4,
   parameter int RLS_DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   output logic                           ocp_req,
   input  logic                           ocp_rsp,
   input  logic [AWIDTH-1:0]              ocp_block_addr,
   input  logic                           ocp_vld,
   input  logic                           mgr_full,
   input  logic                           alloc_req,
   output logic                           alloc_gnt,
   output logic [AWIDTH-1:0]              alloc_addr,
   output logic [cnt_width(PF_DEPTH)-1:0] pf_count,
   input  logic                           free_req,
   input  logic [AWIDTH-1:0]              free_addr,
   output logic                           free_ack,
   output logic                           rls_vld,
   output logic [AWIDTH-1:0]              rls_block_addr
);

   localparam int PF_CW  = cnt_width(PF_DEPTH);
   localparam int RLS_CW = cnt_width(RLS_DEPTH);

   ocp_state_t               state;
   ocp_state_t               state_nxt;
   logic                     ocp_req_nxt;
   logic                     pf_push;
   logic                     pf_empty;
   logic                     pf_full;
   logic [RLS_CW-1:0]        rls_count;
   logic [AWIDTH-1:0]        rls_head;
   logic                     rls_empty;
   logic                     rls_push;

   assign pf_empty  = (pf_count == '0);
   assign pf_full   = (pf_count == PF_CW'(PF_DEPTH));
   assign alloc_gnt = alloc_req && !pf_empty;

   addr_fifo #(
      .WIDTH (AWIDTH),
      .DEPTH (PF_DEPTH)
   ) u_pf_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (pf_push),
      .push_dat (ocp_block_addr),
      .pop      (alloc_gnt),
      .head_dat (alloc_addr),
      .count    (pf_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ocp_req <= 1'b0;
      end else begin
         state   <= state_nxt;
         ocp_req <= ocp_req_nxt;
      end
   end

   // The IDLE guard looks at the occupancy after this cycle's pop, so a grant
   // from a full queue already triggers the refill request.
   always_comb begin
      state_nxt   = state;
      ocp_req_nxt = ocp_req;
      pf_push     = 1'b0;
      case (state)
         IDLE: begin
            if ((!pf_full || alloc_gnt) && !mgr_full) begin
               state_nxt   = REQ;
               ocp_req_nxt = 1'b1;
            end
         end
         REQ: begin
            // No abort here: dropping an outstanding request would orphan a block.
            if (ocp_rsp && ocp_vld) begin
               pf_push     = 1'b1;
               state_nxt   = IDLE;
               ocp_req_nxt = 1'b0;
            end
         end
      endcase
   end

   assign rls_empty = (rls_count == '0);
   assign free_ack  = (rls_count != RLS_CW'(RLS_DEPTH));
   assign rls_push  = free_req && free_ack;

   addr_fifo #(
      .WIDTH (AWIDTH),
      .DEPTH (RLS_DEPTH)
   ) u_rls_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (rls_push),
      .push_dat (free_addr),
      .pop      (!rls_empty),
      .head_dat (rls_head),
      .count    (rls_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rls_vld        <= 1'b0;
         rls_block_addr <= '0;
      end else begin
         rls_vld        <= !rls_empty;
         rls_block_addr <= rls_head;
      end
   end

endmodule

// File: tb/tb_blk_alloc_client.sv
// Bench for blk_alloc_client: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then a randomized soak.
module tb_blk_alloc_client;

   localparam int AW  = 10;
   localparam int PFD = 4;
   localparam int RLD = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ocp_req;
   logic          ocp_rsp;
   logic [AW-1:0] ocp_block_addr;
   logic          ocp_vld;
   logic          mgr_full;
   logic          alloc_req;
   logic          alloc_gnt;
   logic [AW-1:0] alloc_addr;
   logic [2:0]    pf_count;
   logic          free_req;
   logic [AW-1:0] free_addr;
   logic          free_ack;
   logic          rls_vld;
   logic [AW-1:0] rls_block_addr;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit chk_en = 0;

   blk_alloc_client #(
      .AWIDTH    (AW),
      .PF_DEPTH  (PFD),
      .RLS_DEPTH (RLD)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ocp_req        (ocp_req),
      .ocp_rsp        (ocp_rsp),
      .ocp_block_addr (ocp_block_addr),
      .ocp_vld        (ocp_vld),
      .mgr_full       (mgr_full),
      .alloc_req      (alloc_req),
      .alloc_gnt      (alloc_gnt),
      .alloc_addr     (alloc_addr),
      .pf_count       (pf_count),
      .free_req       (free_req),
      .free_addr      (free_addr),
      .free_ack       (free_ack),
      .rls_vld        (rls_vld),
      .rls_block_addr (rls_block_addr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Manager stand-in: answers delay cycles after seeing ocp_req, once per request.
   int mgr_delay = 2;
   bit mgr_bogus = 0;
   int mgr_wait = 0;
   bit mgr_answered = 0;
   int mgr_next = 5;

   initial begin
      ocp_rsp = 1'b0;
      ocp_vld = 1'b0;
      ocp_block_addr = '0;
      forever begin
         @(posedge clk);
         #1;
         ocp_rsp = 1'b0;
         ocp_vld = 1'b0;
         if (rst) begin
            mgr_wait = 0;
            mgr_answered = 0;
         end else if (ocp_req && !mgr_answered) begin
            mgr_wait++;
            if (mgr_wait >= mgr_delay) begin
               ocp_rsp = 1'b1;
               ocp_vld = 1'b1;
               ocp_block_addr = AW'(mgr_next);
               mgr_next++;
               mgr_answered = 1;
               mgr_wait = 0;
            end else if (mgr_bogus && mgr_wait == 3) begin
               ocp_rsp = 1'b1;
            end
         end else if (!ocp_req) begin
            mgr_answered = 0;
         end
      end
   end

   // Reference model: prefetch and release queues plus one outstanding-request flag.
   int pf_q[$];
   int rls_q[$];
   bit m_req = 0;
   bit m_rls_vld = 0;
   int m_rls_addr = 0;
   bit m_gnt;
   bit m_accept;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pf_q.delete();
         rls_q.delete();
         m_req = 0;
         m_rls_vld = 0;
         m_rls_addr = 0;
      end else begin
         m_gnt    = alloc_req && (pf_q.size() > 0);
         m_accept = free_req && (rls_q.size() < RLD);
         if (rls_q.size() > 0) begin
            m_rls_vld  = 1;
            m_rls_addr = rls_q.pop_front();
         end else begin
            m_rls_vld  = 0;
            m_rls_addr = 0;
         end
         if (m_accept) rls_q.push_back(int'(free_addr));
         if (m_gnt) void'(pf_q.pop_front());
         if (m_req) begin
            if (ocp_rsp && ocp_vld) begin
               pf_q.push_back(int'(ocp_block_addr));
               m_req = 0;
            end
         end else begin
            m_req = (pf_q.size() < PFD) && !mgr_full;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ocp_req", ocp_req, m_req);
         chk("alloc_gnt", alloc_gnt, alloc_req && (pf_q.size() > 0));
         chk("alloc_addr", alloc_addr, (pf_q.size() > 0) ? pf_q[0] : 0);
         chk("pf_count", pf_count, pf_q.size());
         chk("free_ack", free_ack, rls_q.size() < RLD);
         chk("rls_vld", rls_vld, m_rls_vld);
         chk("rls_block_addr", rls_block_addr, m_rls_addr);
      end
   end

   // Monitors for literal expectations.
   int ocp_rise_cnt = 0;
   bit ocp_req_d = 0;
   int rls_seen_addr[$];
   int rls_seen_cyc[$];

   always @(negedge clk) begin
      if (ocp_req && !ocp_req_d) ocp_rise_cnt++;
      ocp_req_d <= ocp_req;
      if (rls_vld) begin
         rls_seen_addr.push_back(int'(rls_block_addr));
         rls_seen_cyc.push_back(cyc);
      end
   end

   task automatic do_reset(input bit full_during);
      @(posedge clk);
      #1;
      rst = 1'b1;
      mgr_full = full_during;
      alloc_req = 1'b0;
      free_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      ocp_rise_cnt = 0;
   endtask

   task automatic wait_req_high(input string name);
      int k;
      k = 0;
      while (!ocp_req && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk(name, ocp_req, 1);
   endtask

   int n_start;
   int exp_addr;

   initial begin
      mgr_full = 1'b0;
      alloc_req = 1'b0;
      free_req = 1'b0;
      free_addr = '0;
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ocp_req", ocp_req, 0);
      chk("reset_free_ack", free_ack, 1);
      chk("reset_pf_count", pf_count, 0);
      chk("reset_rls_vld", rls_vld, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      ocp_rise_cnt = 0;

      // Fill prefetch queue with an always-ready manager.
      for (int k = 0; k < 60 && pf_count != 3'd4; k++) @(negedge clk);
      repeat (10) @(negedge clk);
      chk("fill_pf_count", pf_count, 4);
      chk("fill_req_pulses", ocp_rise_cnt, 4);
      chk("fill_head", alloc_addr, 5);
      chk("fill_req_idle", ocp_req, 0);

      // Drain four grants; refill request follows the first pop.
      @(posedge clk);
      #1;
      alloc_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("drain_gnt", alloc_gnt, 1);
         chk("drain_addr", alloc_addr, 5 + i);
         if (i == 1) chk("refill_start", ocp_req, 1);
         @(posedge clk);
         #1;
      end
      alloc_req = 1'b0;
      repeat (25) @(negedge clk);
      chk("refill_count", pf_count, 4);
      chk("refill_head", alloc_addr, 9);

      // Manager full from reset: no request, no grant.
      do_reset(1'b1);
      repeat (20) @(negedge clk);
      chk("full_no_req", ocp_rise_cnt, 0);
      @(posedge clk);
      #1;
      alloc_req = 1'b1;
      @(negedge clk);
      chk("empty_gnt", alloc_gnt, 0);
      chk("empty_addr", alloc_addr, 0);
      @(posedge clk);
      #1;
      alloc_req = 1'b0;

      // Ten back-to-back releases.
      rls_seen_addr.delete();
      rls_seen_cyc.delete();
      n_start = cyc;
      for (int i = 0; i < 10; i++) begin
         free_req = 1'b1;
         free_addr = AW'(12'h3A0 + i);
         @(posedge clk);
         #1;
      end
      free_req = 1'b0;
      repeat (12) @(negedge clk);
      chk("rls_pulses", rls_seen_addr.size(), 10);
      if (rls_seen_addr.size() == 10) begin
         chk("rls_first_cycle", rls_seen_cyc[0], n_start + 2);
         for (int i = 0; i < 10; i++) begin
            chk("rls_order", rls_seen_addr[i], 'h3A0 + i);
            chk("rls_back_to_back", rls_seen_cyc[i], n_start + 2 + i);
         end
      end

      // Slow manager with mgr_full toggling: the request must be held.
      do_reset(1'b0);
      mgr_delay = 20;
      mgr_bogus = 1;
      exp_addr = mgr_next;
      wait_req_high("slow_req_rise");
      for (int i = 0; i < 18; i++) begin
         @(posedge clk);
         #1;
         mgr_full = ~mgr_full;
         @(negedge clk);
         chk("slow_req_held", ocp_req, 1);
      end
      @(posedge clk);
      #1;
      mgr_full = 1'b1;
      repeat (10) @(negedge clk);
      chk("slow_one_queued", pf_count, 1);
      chk("slow_addr", alloc_addr, exp_addr);
      chk("slow_one_req", ocp_rise_cnt, 1);

      // Reset during REQ with releases in flight.
      mgr_bogus = 0;
      do_reset(1'b0);
      wait_req_high("rst_req_rise");
      @(posedge clk);
      #1;
      free_req = 1'b1;
      free_addr = AW'(10'h111);
      @(posedge clk);
      #1;
      free_addr = AW'(10'h222);
      @(posedge clk);
      #1;
      free_req = 1'b0;
      mgr_full = 1'b1;
      rst = 1'b1;
      rls_seen_addr.delete();
      #1;
      chk("rst_ocp_req", ocp_req, 0);
      chk("rst_rls_vld", rls_vld, 0);
      chk("rst_rls_addr", rls_block_addr, 0);
      chk("rst_pf_count", pf_count, 0);
      chk("rst_alloc_gnt", alloc_gnt, 0);
      chk("rst_alloc_addr", alloc_addr, 0);
      chk("rst_free_ack", free_ack, 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("rst_no_release", rls_seen_addr.size(), 0);

      // Randomized soak.
      do_reset(1'b0);
      for (int i = 0; i < 800; i++) begin
         @(posedge clk);
         #1;
         alloc_req = ($urandom_range(0, 2) == 0);
         mgr_full  = ($urandom_range(0, 4) == 0);
         free_req  = ($urandom_range(0, 1) == 1);
         free_addr = AW'($urandom_range(0, 1023));
         mgr_delay = $urandom_range(2, 6);
         mgr_bogus = ($urandom_range(0, 3) == 0);
      end
      alloc_req = 1'b0;
      free_req = 1'b0;
      repeat (12) @(negedge clk);

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
